// File: rtl/vga_rd_pkg.sv
// vga_rd_pkg: shared constants for the VGA read scheduler.
// Holds the scheduler state encoding, the VTC resolution presets and the
// burst-length helper used when sizing each read request.
package vga_rd_pkg;

    // Scheduler state encoding (plain constants for legacy tool compatibility)
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_FLUSH = 3'd1;
    localparam state_t ST_ARB   = 3'd2;
    localparam state_t ST_REQ   = 3'd3;
    localparam state_t ST_WAIT  = 3'd4;
    localparam state_t ST_DONE  = 3'd5;

    // Active-area presets matching the VTC timing generator modes
    localparam int unsigned H_ACTIVE_480P  = 640;
    localparam int unsigned V_ACTIVE_480P  = 480;
    localparam int unsigned H_ACTIVE_720P  = 1280;
    localparam int unsigned V_ACTIVE_720P  = 720;
    localparam int unsigned H_ACTIVE_1080P = 1920;
    localparam int unsigned V_ACTIVE_1080P = 1080;

    // Smaller of two 16-bit lengths; used to clip a burst at the line end
    function automatic logic [15:0] min_len(input logic [15:0] a, input logic [15:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/vga_edge_det.sv
// vga_edge_det: falling-edge detector for the active-low vsync.
// The history register resets to 1 so a vsync already held low when reset
// releases is seen as a fresh frame start.
module vga_edge_det (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sig_i,
    output logic fall_o
);

    logic sig_q;

    // Register the previous level of the input
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sig_q <= 1'b1;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign fall_o = sig_q & ~sig_i;

endmodule

// File: rtl/vga_rd_sched.sv
// vga_rd_sched: line-prefetch read scheduler in the pixel clock domain.
// Walks the active frame in bursts that never cross a line, throttled by the
// line FIFO level, restarting at every vsync falling edge. An in-flight burst
// is always allowed to finish before a restart takes effect.
// Optional double buffering is enabled by defining VGA_RD_DBUF_EN.
module vga_rd_sched
    import vga_rd_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = 1280,
    parameter int unsigned V_ACTIVE    = 720,
    parameter int unsigned BURST_LEN   = 64,
    parameter int unsigned FIFO_DEPTH  = 2048,
    parameter int          LVL_W       = 12,
    parameter int          ADDR_W      = 28,
    parameter int unsigned LINE_STRIDE = 1280,
    parameter int unsigned FB_BASE0    = 0,
    parameter int unsigned FB_BASE1    = 921600
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              vsync_i,
    input  logic              de_i,
    input  logic [LVL_W-1:0]  fifo_level_i,
    output logic              fifo_flush_o,
    output logic              rd_req_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic [7:0]        rd_len_o,
    input  logic              rd_ack_i,
    input  logic              rd_done_i,
    output logic              underflow_o,
`ifdef VGA_RD_DBUF_EN
    input  logic              fb_swap_i,
    output logic              fb_sel_o,
`endif
    output logic [15:0]       frame_cnt_o
);

    localparam logic [1:0][ADDR_W-1:0] FB_BASES = {ADDR_W'(FB_BASE1), ADDR_W'(FB_BASE0)};

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   line_addr_q, line_addr_d;
    logic [15:0]         col_q, col_d;
    logic [15:0]         line_q, line_d;
    logic [15:0]         len_q, len_d;
    logic                restart_pend_q, restart_pend_d;
    logic                fifo_flush_q, fifo_flush_d;
    logic                rd_req_q, rd_req_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [7:0]          rd_len_q, rd_len_d;
    logic                underflow_q, underflow_d;
    logic [15:0]         frame_cnt_q, frame_cnt_d;

    logic                frame_start;
    logic                base_sel;
    logic [ADDR_W-1:0]   fb_base;
    logic [LVL_W:0]      room_sum;
    logic                has_room;
    logic [15:0]         next_len;
    logic [15:0]         col_sum;

    vga_edge_det u_vs_edge (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .sig_i  (vsync_i),
        .fall_o (frame_start)
    );

`ifdef VGA_RD_DBUF_EN
    logic swap_pend_q, swap_pend_d;
    logic fb_sel_q, fb_sel_d;

    // The buffer chosen at FLUSH already includes any pending swap
    assign base_sel = fb_sel_q ^ swap_pend_q;

    // Hold a swap request until the next frame boundary
    always_comb begin
        swap_pend_d = swap_pend_q | fb_swap_i;
        fb_sel_d    = fb_sel_q;
        if (state_q == ST_FLUSH) begin
            swap_pend_d = fb_swap_i;
            fb_sel_d    = base_sel;
        end
    end

    // Buffer selection registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            swap_pend_q <= 1'b0;
            fb_sel_q    <= 1'b0;
        end else begin
            swap_pend_q <= swap_pend_d;
            fb_sel_q    <= fb_sel_d;
        end
    end

    assign fb_sel_o = fb_sel_q;
`else
    assign base_sel = 1'b0;
`endif

    assign fb_base  = FB_BASES[base_sel];
    assign room_sum = {1'b0, fifo_level_i} + (LVL_W+1)'(BURST_LEN);
    assign has_room = (room_sum <= (LVL_W+1)'(FIFO_DEPTH));
    assign next_len = min_len(16'(BURST_LEN), 16'(H_ACTIVE) - col_q);
    assign col_sum  = col_q + len_q;

    // Next-state and datapath decisions for the burst scheduler
    always_comb begin
        state_d        = state_q;
        line_addr_d    = line_addr_q;
        col_d          = col_q;
        line_d         = line_q;
        len_d          = len_q;
        restart_pend_d = restart_pend_q;
        rd_addr_d      = rd_addr_q;
        rd_len_d       = rd_len_q;
        frame_cnt_d    = frame_cnt_q;
        underflow_d    = underflow_q | (de_i && (fifo_level_i == '0));

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (frame_start) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                line_addr_d    = fb_base;
                col_d          = '0;
                line_d         = '0;
                restart_pend_d = 1'b0;
                frame_cnt_d    = frame_cnt_q + 16'd1;
                state_d        = ST_ARB;
            end
            ST_ARB: begin
                if (frame_start) begin
                    state_d = ST_FLUSH;
                end else if (line_q == 16'(V_ACTIVE)) begin
                    state_d = ST_DONE;
                end else if (has_room) begin
                    len_d     = next_len;
                    rd_addr_d = line_addr_q + ADDR_W'(col_q);
                    rd_len_d  = next_len[7:0];
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                if (rd_ack_i) begin
                    state_d = ST_WAIT;
                    if (frame_start) begin
                        restart_pend_d = 1'b1;
                    end
                end else if (frame_start) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_WAIT: begin
                if (rd_done_i) begin
                    if (restart_pend_q || frame_start) begin
                        state_d = ST_FLUSH;
                    end else begin
                        if (col_sum >= 16'(H_ACTIVE)) begin
                            col_d       = '0;
                            line_d      = line_q + 16'd1;
                            line_addr_d = line_addr_q + ADDR_W'(LINE_STRIDE);
                        end else begin
                            col_d = col_sum;
                        end
                        state_d = ST_ARB;
                    end
                end else if (frame_start) begin
                    restart_pend_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        fifo_flush_d = (state_d == ST_FLUSH);
        rd_req_d     = (state_d == ST_REQ);
    end

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= ST_IDLE;
            line_addr_q    <= '0;
            col_q          <= '0;
            line_q         <= '0;
            len_q          <= '0;
            restart_pend_q <= 1'b0;
            fifo_flush_q   <= 1'b0;
            rd_req_q       <= 1'b0;
            rd_addr_q      <= '0;
            rd_len_q       <= '0;
            underflow_q    <= 1'b0;
            frame_cnt_q    <= '0;
        end else begin
            state_q        <= state_d;
            line_addr_q    <= line_addr_d;
            col_q          <= col_d;
            line_q         <= line_d;
            len_q          <= len_d;
            restart_pend_q <= restart_pend_d;
            fifo_flush_q   <= fifo_flush_d;
            rd_req_q       <= rd_req_d;
            rd_addr_q      <= rd_addr_d;
            rd_len_q       <= rd_len_d;
            underflow_q    <= underflow_d;
            frame_cnt_q    <= frame_cnt_d;
        end
    end

    assign fifo_flush_o = fifo_flush_q;
    assign rd_req_o     = rd_req_q;
    assign rd_addr_o    = rd_addr_q;
    assign rd_len_o     = rd_len_q;
    assign underflow_o  = underflow_q;
    assign frame_cnt_o  = frame_cnt_q;

endmodule

// File: tb/tb_vga_rd_sched.sv
// tb_vga_rd_sched: two scheduler instances (8-pixel and 6-pixel lines) share
// one stimulus stream; each is checked against a burst plan built from the
// frame geometry. Define VGA_RD_DBUF_EN to also exercise buffer swapping.
module tb_vga_rd_sched;

    localparam int H8     = 8;
    localparam int H6     = 6;
    localparam int V      = 2;
    localparam int BL     = 4;
    localparam int DEPTH  = 16;
    localparam int LW     = 5;
    localparam int AW     = 28;
    localparam int STRIDE = 16;
    localparam int BASE0  = 'h100;
    localparam int BASE1  = 'h800;

    logic          clk = 1'b0;
    logic          rst;
    logic          vsync;
    logic          de;
    logic [LW-1:0] fifo_level;
    logic          rd_ack;
    logic          rd_done;

    logic          flushA, reqA, ufA;
    logic [AW-1:0] addrA;
    logic [7:0]    lenA;
    logic [15:0]   fcA;
    logic          flushB, reqB, ufB;
    logic [AW-1:0] addrB;
    logic [7:0]    lenB;
    logic [15:0]   fcB;

`ifdef VGA_RD_DBUF_EN
    logic fb_swap;
    logic selA, selB;
    int   selExp;
    bit   swapPend;
`endif

    int tests = 0;
    int fails = 0;

    int fcExp;
    bit ufExp;
    int curBase;
    logic [AW-1:0] planAddrA[$];
    logic [AW-1:0] planAddrB[$];
    int            planLenA[$];
    int            planLenB[$];

    always #5 clk = ~clk;

    vga_rd_sched #(
        .H_ACTIVE(H8), .V_ACTIVE(V), .BURST_LEN(BL), .FIFO_DEPTH(DEPTH), .LVL_W(LW),
        .ADDR_W(AW), .LINE_STRIDE(STRIDE), .FB_BASE0(BASE0), .FB_BASE1(BASE1)
    ) dutA (
        .clk_i(clk), .rst_i(rst), .vsync_i(vsync), .de_i(de), .fifo_level_i(fifo_level),
        .fifo_flush_o(flushA), .rd_req_o(reqA), .rd_addr_o(addrA), .rd_len_o(lenA),
        .rd_ack_i(rd_ack), .rd_done_i(rd_done), .underflow_o(ufA),
`ifdef VGA_RD_DBUF_EN
        .fb_swap_i(fb_swap), .fb_sel_o(selA),
`endif
        .frame_cnt_o(fcA)
    );

    vga_rd_sched #(
        .H_ACTIVE(H6), .V_ACTIVE(V), .BURST_LEN(BL), .FIFO_DEPTH(DEPTH), .LVL_W(LW),
        .ADDR_W(AW), .LINE_STRIDE(STRIDE), .FB_BASE0(BASE0), .FB_BASE1(BASE1)
    ) dutB (
        .clk_i(clk), .rst_i(rst), .vsync_i(vsync), .de_i(de), .fifo_level_i(fifo_level),
        .fifo_flush_o(flushB), .rd_req_o(reqB), .rd_addr_o(addrB), .rd_len_o(lenB),
        .rd_ack_i(rd_ack), .rd_done_i(rd_done), .underflow_o(ufB),
`ifdef VGA_RD_DBUF_EN
        .fb_swap_i(fb_swap), .fb_sel_o(selB),
`endif
        .frame_cnt_o(fcB)
    );

    // Let one clock edge sample the current inputs, then settle
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expected burst list for a frame: walk each line in BL-sized chunks
    task automatic buildPlans();
        planAddrA.delete();
        planAddrB.delete();
        planLenA.delete();
        planLenB.delete();
        for (int ln = 0; ln < V; ln++) begin
            int col;
            int n;
            col = 0;
            while (col < H8) begin
                n = (H8 - col < BL) ? (H8 - col) : BL;
                planAddrA.push_back(AW'(curBase + ln * STRIDE + col));
                planLenA.push_back(n);
                col += n;
            end
            col = 0;
            while (col < H6) begin
                n = (H6 - col < BL) ? (H6 - col) : BL;
                planAddrB.push_back(AW'(curBase + ln * STRIDE + col));
                planLenB.push_back(n);
                col += n;
            end
        end
    endtask

    task automatic checkPair(input string tag, input logic a, input logic b, input logic exp);
        checkOutput({tag, "_A"}, a, exp);
        checkOutput({tag, "_B"}, b, exp);
    endtask

    // Called while the DUTs sit in FLUSH; advances into ARB and checks frame state
    task automatic flushSequence(input string tag);
        checkPair({tag, "_flush"}, flushA, flushB, 1'b1);
        checkPair({tag, "_req_in_flush"}, reqA, reqB, 1'b0);
        applyStimulus();
        fcExp = (fcExp + 1) % 65536;
`ifdef VGA_RD_DBUF_EN
        if (swapPend) begin
            selExp   = selExp ^ 1;
            swapPend = 1'b0;
        end
        curBase = (selExp != 0) ? BASE1 : BASE0;
        checkPair({tag, "_fb_sel"}, selA, selB, selExp[0]);
`endif
        buildPlans();
        checkPair({tag, "_flush_one_cycle"}, flushA, flushB, 1'b0);
        checkOutput({tag, "_frame_cnt_A"}, fcA, fcExp);
        checkOutput({tag, "_frame_cnt_B"}, fcB, fcExp);
        checkPair({tag, "_underflow"}, ufA, ufB, ufExp);
    endtask

    task automatic startFrame();
        vsync = 1'b0;
        applyStimulus();
        vsync = 1'b1;
        flushSequence("start");
    endtask

    task automatic waitReq(input int maxCycles, input string tag);
        int n;
        n = 0;
        while (reqA !== 1'b1 && n < maxCycles) begin
            applyStimulus();
            n++;
        end
        checkPair(tag, reqA, reqB, 1'b1);
    endtask

    task automatic checkBurst(input int k, input string tag);
        checkOutput($sformatf("%s_addr_A_%0d", tag, k), addrA, planAddrA[k]);
        checkOutput($sformatf("%s_addr_B_%0d", tag, k), addrB, planAddrB[k]);
        checkOutput($sformatf("%s_len_A_%0d", tag, k), lenA, planLenA[k]);
        checkOutput($sformatf("%s_len_B_%0d", tag, k), lenB, planLenB[k]);
    endtask

    // Serve a whole frame; mode picks an optional restart:
    // 1 vsync in WAIT, 2 vsync in REQ before ack, 3 vsync in ARB, 4 vsync with ack
    task automatic doBursts(input int kind, input int abortAt);
        int k;
        int mode;
        k = 0;
        mode = kind;
        while (k < planAddrA.size()) begin
            if (mode == 3 && k == abortAt) begin
                fifo_level = 5'd16;
                applyStimulus();
                checkPair("arb_hold", reqA, reqB, 1'b0);
                vsync = 1'b0;
                applyStimulus();
                vsync = 1'b1;
                flushSequence("arb_abort");
                k = 0;
                mode = 0;
                continue;
            end
            if ($urandom_range(0, 1) == 1) begin
                fifo_level = 5'($urandom_range(13, 16));
                repeat (3) begin
                    applyStimulus();
                    checkPair("backpressure_no_req", reqA, reqB, 1'b0);
                end
                rd_done = 1'b1;
                applyStimulus();
                rd_done = 1'b0;
                checkPair("stray_done_no_req", reqA, reqB, 1'b0);
                fifo_level = 5'($urandom_range(0, 12));
                waitReq(2, "backpressure_release");
            end else begin
                fifo_level = 5'($urandom_range(0, 12));
                waitReq(2, "req_after_arb");
            end
            checkBurst(k, "req");
            if (mode == 2 && k == abortAt) begin
                vsync = 1'b0;
                applyStimulus();
                vsync = 1'b1;
                flushSequence("req_abort");
                k = 0;
                mode = 0;
                continue;
            end
            repeat ($urandom_range(0, 3)) begin
                applyStimulus();
                checkPair("req_held", reqA, reqB, 1'b1);
                checkBurst(k, "held");
            end
            if (mode == 4 && k == abortAt) vsync = 1'b0;
            rd_ack = 1'b1;
            applyStimulus();
            rd_ack = 1'b0;
            vsync = 1'b1;
            checkPair("req_drop_after_ack", reqA, reqB, 1'b0);
            if ((mode == 1 || mode == 4) && k == abortAt) begin
                if (mode == 1) begin
                    vsync = 1'b0;
                    applyStimulus();
                    vsync = 1'b1;
                end
                checkPair("burst_not_abandoned", flushA, flushB, 1'b0);
                repeat ($urandom_range(0, 2)) applyStimulus();
                rd_done = 1'b1;
                applyStimulus();
                rd_done = 1'b0;
                flushSequence("wait_abort");
                k = 0;
                mode = 0;
                continue;
            end
            repeat ($urandom_range(0, 3)) applyStimulus();
            rd_done = 1'b1;
            applyStimulus();
            rd_done = 1'b0;
            checkPair("gap_after_done", reqA, reqB, 1'b0);
            checkPair("no_flush_mid_frame", flushA, flushB, 1'b0);
            k++;
        end
        repeat (3) begin
            applyStimulus();
            checkPair("done_no_req", reqA, reqB, 1'b0);
        end
    endtask

    task automatic checkReset(input string tag);
        checkPair({tag, "_flush"}, flushA, flushB, 1'b0);
        checkPair({tag, "_req"}, reqA, reqB, 1'b0);
        checkPair({tag, "_underflow"}, ufA, ufB, 1'b0);
        checkOutput({tag, "_addr_A"}, addrA, 0);
        checkOutput({tag, "_addr_B"}, addrB, 0);
        checkOutput({tag, "_len_A"}, lenA, 0);
        checkOutput({tag, "_len_B"}, lenB, 0);
        checkOutput({tag, "_frame_cnt_A"}, fcA, 0);
        checkOutput({tag, "_frame_cnt_B"}, fcB, 0);
`ifdef VGA_RD_DBUF_EN
        checkPair({tag, "_fb_sel"}, selA, selB, 1'b0);
`endif
    endtask

    initial begin
        rst        = 1'b1;
        vsync      = 1'b1;
        de         = 1'b0;
        fifo_level = '0;
        rd_ack     = 1'b0;
        rd_done    = 1'b0;
`ifdef VGA_RD_DBUF_EN
        fb_swap  = 1'b0;
        selExp   = 0;
        swapPend = 1'b0;
`endif
        curBase = BASE0;
        fcExp   = 0;
        ufExp   = 1'b0;
        buildPlans();

        applyStimulus();
        applyStimulus();
        checkReset("reset");
        rst = 1'b0;
        repeat (4) applyStimulus();
        checkPair("idle_no_req", reqA, reqB, 1'b0);
        checkPair("idle_no_flush", flushA, flushB, 1'b0);

        startFrame();
        doBursts(0, -1);

        checkPair("underflow_before", ufA, ufB, 1'b0);
        de = 1'b1;
        fifo_level = 5'd1;
        applyStimulus();
        checkPair("underflow_level_one", ufA, ufB, 1'b0);
        fifo_level = 5'd0;
        applyStimulus();
        de = 1'b0;
        fifo_level = 5'd8;
        ufExp = 1'b1;
        applyStimulus();
        checkPair("underflow_set", ufA, ufB, 1'b1);

        startFrame();
        doBursts(1, 1);
        startFrame();
        doBursts(2, 2);
        startFrame();
        doBursts(3, 1);
        startFrame();
        doBursts(4, 0);

`ifdef VGA_RD_DBUF_EN
        startFrame();
        fifo_level = 5'd16;
        fb_swap = 1'b1;
        applyStimulus();
        fb_swap = 1'b0;
        swapPend = 1'b1;
        checkPair("swap_no_req", reqA, reqB, 1'b0);
        doBursts(0, -1);
        checkPair("swap_not_mid_frame", selA, selB, 1'b0);
        startFrame();
        doBursts(0, -1);
`endif

        repeat (3) begin
            startFrame();
            doBursts(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
        end

        fifo_level = 5'd0;
        startFrame();
        waitReq(2, "rst_mid_req");
        rd_ack = 1'b1;
        applyStimulus();
        rd_ack = 1'b0;
        rst = 1'b1;
        vsync = 1'b0;
        applyStimulus();
        fcExp = 0;
        ufExp = 1'b0;
`ifdef VGA_RD_DBUF_EN
        selExp   = 0;
        swapPend = 1'b0;
`endif
        curBase = BASE0;
        buildPlans();
        checkReset("reset_mid_burst");
        applyStimulus();
        rst = 1'b0;
        applyStimulus();
        vsync = 1'b1;
        flushSequence("post_reset_start");
        doBursts(0, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
